// File: rtl/wb_queue_if.sv
// Bus bundle between execute, the writeback queue and the register-bank write port.
// The queue side is the slave: it accepts results and drives the bank write strobe.
interface wb_queue_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          drain_en;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;

    // Execute / register-bank side
    modport master (
        output in_valid, in_addr, in_data, drain_en,
        input  in_ready, wb_en, wb_addr, wb_data
    );

    // Writeback queue side
    modport slave (
        input  in_valid, in_addr, in_data, drain_en,
        output in_ready, wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/wb_queue.sv
// In-order writeback queue feeding the register bank, with two forwarding
// lookup ports that see every write not yet committed to the bank.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    wb_queue_if.slave                bus,
    input  logic [AW-1:0]            lk1_addr,
    input  logic [AW-1:0]            lk2_addr,
    output logic                     fwd1_hit,
    output logic                     fwd2_hit,
    output logic [DW-1:0]            fwd1_data,
    output logic [DW-1:0]            fwd2_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage; not reset, occupancy is tracked by the pointers.
    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          wb_en_reg;
    logic [AW-1:0] wb_addr_reg;
    logic [DW-1:0] wb_data_reg;

    logic          push;
    logic          pop;

    // Flags are decoded from the pre-edge count, so a push into an empty
    // queue cannot pop on the same edge and a full queue never pushes.
    assign empty        = (count_reg == '0);
    assign full         = (count_reg == CW'(DEPTH));
    assign bus.in_ready = !full;
    assign push         = bus.in_valid && !full;
    assign pop          = bus.drain_en && !empty;

    assign count       = count_reg;
    assign bus.wb_en   = wb_en_reg;
    assign bus.wb_addr = wb_addr_reg;
    assign bus.wb_data = wb_data_reg;

    // Occupancy update: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Pointers, occupancy and the registered bank write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
            wb_en_reg   <= 1'b0;
            wb_addr_reg <= '0;
            wb_data_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg    <= head_reg + 1'b1;
                wb_en_reg   <= 1'b1;
                wb_addr_reg <= addr_mem[head_reg];
                wb_data_reg <= data_mem[head_reg];
            end else begin
                wb_en_reg <= 1'b0;
            end
        end
    end

    // Write accepted results at the tail slot.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_reg] <= bus.in_addr;
            data_mem[tail_reg] <= bus.in_data;
        end
    end

    // Age-ordered view of the storage: age 0 is the head (oldest entry).
    logic [PW-1:0] age_idx  [DEPTH];
    logic          age_live [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            assign age_idx[gi]  = head_reg + PW'(gi);
            assign age_live[gi] = (CW'(gi) < count_reg);
        end
    endgenerate

    logic [AW-1:0] lk_addr  [2];
    logic          hit_vec  [2];
    logic [DW-1:0] data_vec [2];

    assign lk_addr[0] = lk1_addr;
    assign lk_addr[1] = lk2_addr;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            // Scan oldest to youngest so the youngest matching write wins;
            // the wb register is older than every queued entry.
            always_comb begin
                hit_vec[gi]  = 1'b0;
                data_vec[gi] = '0;
                if (wb_en_reg && (wb_addr_reg == lk_addr[gi])) begin
                    hit_vec[gi]  = 1'b1;
                    data_vec[gi] = wb_data_reg;
                end
                for (int k = 0; k < DEPTH; k++) begin
                    if (age_live[k] && (addr_mem[age_idx[k]] == lk_addr[gi])) begin
                        hit_vec[gi]  = 1'b1;
                        data_vec[gi] = data_mem[age_idx[k]];
                    end
                end
            end
        end
    endgenerate

    assign fwd1_hit  = hit_vec[0];
    assign fwd1_data = data_vec[0];
    assign fwd2_hit  = hit_vec[1];
    assign fwd2_data = data_vec[1];
endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue with a queue-based reference model and a
// per-cycle comparison of every output.
module tb_wb_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 4;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] lk1_addr = '0;
    logic [AW-1:0] lk2_addr = '0;
    logic          fwd1_hit, fwd2_hit;
    logic [DW-1:0] fwd1_data, fwd2_data;
    logic [2:0]    count;
    logic          empty, full;

    int checks   = 0;
    int failures = 0;

    wb_queue_if #(.AW(AW), .DW(DW)) bus ();

    wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .lk1_addr  (lk1_addr),
        .lk2_addr  (lk2_addr),
        .fwd1_hit  (fwd1_hit),
        .fwd2_hit  (fwd2_hit),
        .fwd1_data (fwd1_data),
        .fwd2_data (fwd2_data),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [AW-1:0] mq_addr [$];
    logic [DW-1:0] mq_data [$];
    logic          m_wb_en;
    logic [AW-1:0] m_wb_addr;
    logic [DW-1:0] m_wb_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq_addr.delete();
            mq_data.delete();
            m_wb_en   = 1'b0;
            m_wb_addr = '0;
            m_wb_data = '0;
        end else begin
            bit do_pop, do_push;
            do_pop  = bus.drain_en && (mq_addr.size() > 0);
            do_push = bus.in_valid && (mq_addr.size() < DEPTH);
            if (do_pop) begin
                m_wb_en   = 1'b1;
                m_wb_addr = mq_addr.pop_front();
                m_wb_data = mq_data.pop_front();
            end else begin
                m_wb_en = 1'b0;
            end
            if (do_push) begin
                mq_addr.push_back(bus.in_addr);
                mq_data.push_back(bus.in_data);
            end
        end
    end

    // Newest pending write to 'a': queue back-to-front, then the wb register.
    function automatic logic [DW:0] model_fwd(input logic [AW-1:0] a);
        for (int i = mq_addr.size() - 1; i >= 0; i--) begin
            if (mq_addr[i] == a) return {1'b1, mq_data[i]};
        end
        if (m_wb_en && m_wb_addr == a) return {1'b1, m_wb_data};
        return {1'b0, {DW{1'b0}}};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [DW:0] f1, f2;
        int sz;
        f1 = model_fwd(lk1_addr);
        f2 = model_fwd(lk2_addr);
        sz = mq_addr.size();
        chk("m_in_ready", 32'(bus.in_ready), 32'(sz < DEPTH));
        chk("m_count",    32'(count),        32'(sz));
        chk("m_empty",    32'(empty),        32'(sz == 0));
        chk("m_full",     32'(full),         32'(sz == DEPTH));
        chk("m_wb_en",    32'(bus.wb_en),    32'(m_wb_en));
        chk("m_wb_addr",  32'(bus.wb_addr),  32'(m_wb_addr));
        chk("m_wb_data",  bus.wb_data,       m_wb_data);
        chk("m_fwd1_hit", 32'(fwd1_hit),     32'(f1[DW]));
        chk("m_fwd1_data", fwd1_data,        f1[DW-1:0]);
        chk("m_fwd2_hit", 32'(fwd2_hit),     32'(f2[DW]));
        chk("m_fwd2_data", fwd2_data,        f2[DW-1:0]);
        $display("cyc t=%0t v=%0b rdy=%0b d=%0b wb=%0b a=%0d data=0x%08h cnt=%0d",
                 $time, bus.in_valid, bus.in_ready, bus.drain_en, bus.wb_en,
                 bus.wb_addr, bus.wb_data, count);
    end

    // One clock edge, then settle just after the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic dr);
        bus.in_valid = v;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.drain_en = dr;
    endtask

    initial begin
        int idx;
        bit acc;
        logic [AW-1:0] last_a;
        drive(0, '0, '0, 0);
        #1 rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_empty",    32'(empty),        32'd1);
        chk("rst_full",     32'(full),         32'd0);
        chk("rst_count",    32'(count),        32'd0);
        chk("rst_wb_en",    32'(bus.wb_en),    32'd0);
        chk("rst_hit",      32'({fwd1_hit, fwd2_hit}), 32'd0);

        // Push then drain: wb_en rises after the second edge
        drive(1, 4'd3, 32'hDEAD0003, 1);
        cyc();
        chk("t1_wb_en_n", 32'(bus.wb_en), 32'd0);
        chk("t1_count_n", 32'(count),     32'd1);
        drive(0, '0, '0, 1);
        cyc();
        chk("t1_wb_en",   32'(bus.wb_en),   32'd1);
        chk("t1_wb_addr", 32'(bus.wb_addr), 32'd3);
        chk("t1_wb_data", bus.wb_data,      32'hDEAD0003);
        chk("t1_count",   32'(count),       32'd0);
        cyc();

        // Fill, overflow attempt, in-order drain
        for (int i = 1; i <= 4; i++) begin
            drive(1, AW'(i), 32'h100 + 32'(i), 0);
            cyc();
        end
        chk("t2_full",  32'(full),         32'd1);
        chk("t2_ready", 32'(bus.in_ready), 32'd0);
        chk("t2_count", 32'(count),        32'd4);
        drive(1, 4'd9, 32'h999, 0);
        cyc();
        chk("t2_count_ovf", 32'(count), 32'd4);
        drive(0, '0, '0, 1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("t2_wb_addr", 32'(bus.wb_addr), 32'(i));
            chk("t2_wb_data", bus.wb_data,      32'h100 + 32'(i));
        end
        cyc();
        chk("t2_wb_idle", 32'(bus.wb_en), 32'd0);

        // Youngest of two same-address entries forwards
        drive(1, 4'd5, 32'h11, 0);
        cyc();
        drive(1, 4'd5, 32'h22, 0);
        cyc();
        drive(0, '0, '0, 0);
        lk1_addr = 4'd5;
        lk2_addr = 4'd6;
        #1;
        chk("t3_hit1",  32'(fwd1_hit), 32'd1);
        chk("t3_data1", fwd1_data,     32'h22);
        chk("t3_hit2",  32'(fwd2_hit), 32'd0);
        chk("t3_data2", fwd2_data,     32'h0);
        drive(0, '0, '0, 1);
        repeat (3) cyc();

        // Queue entry outranks the wb register
        lk1_addr = 4'd7;
        drive(1, 4'd7, 32'h55, 0);
        cyc();
        drive(1, 4'd7, 32'hAA, 1);
        cyc();
        chk("t4_wb_en",  32'(bus.wb_en), 32'd1);
        chk("t4_wbdata", bus.wb_data,    32'h55);
        chk("t4_fwd_q",  fwd1_data,      32'hAA);
        drive(0, '0, '0, 1);
        cyc();
        chk("t4_fwd_wb",  fwd1_data,      32'hAA);
        chk("t4_hit_wb",  32'(fwd1_hit),  32'd1);
        chk("t4_empty",   32'(empty),     32'd1);
        cyc();
        chk("t4_hit_off", 32'(fwd1_hit),  32'd0);

        // Full queue with push and drain together, then continuous streaming
        for (int i = 0; i < 4; i++) begin
            drive(1, AW'(8 + i), 32'hB000_0000 + 32'(i), 0);
            cyc();
        end
        drive(1, 4'd12, 32'hB000_0004, 1);
        cyc();
        chk("t5_count3",  32'(count),       32'd3);
        chk("t5_wb_addr", 32'(bus.wb_addr), 32'd8);
        drive(1, 4'd12, 32'hB000_0004, 0);
        cyc();
        chk("t5_count4", 32'(count), 32'd4);
        idx = 0;
        last_a = '0;
        for (int c = 0; c < 14; c++) begin
            drive(1, AW'(13 + idx), 32'hC000_0000 + 32'(idx), 1);
            acc = bus.in_ready;
            cyc();
            if (acc) begin
                last_a = AW'(13 + idx);
                idx++;
            end
        end
        chk("t5_stream_cnt", 32'(count),     32'd3);
        chk("t5_stream_wb",  32'(bus.wb_en), 32'd1);
        lk1_addr = last_a;
        #1;
        chk("t5_last_hit",  32'(fwd1_hit), 32'd1);
        chk("t5_last_data", fwd1_data,     32'hC000_0000 + 32'(idx - 1));

        // Asynchronous reset with entries pending and a write in flight
        drive(0, '0, '0, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_wb_en",  32'(bus.wb_en), 32'd0);
        chk("t6_empty",  32'(empty),     32'd1);
        chk("t6_count",  32'(count),     32'd0);
        chk("t6_hits",   32'({fwd1_hit, fwd2_hit}), 32'd0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t6_no_wb", 32'(bus.wb_en), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_queue.md
# wb_queue

Writeback queue between the execute stage and the 16 x 32-bit register bank. Results (destination register, 32-bit value) from execute are buffered in a small in-order FIFO and retired to the register bank at most one per cycle, whenever the bank's write slot is granted. Entries not yet in the register bank are exposed to operand fetch through two forwarding lookup ports, so reads never see stale data.

## Interface
- DEPTH, 4, number of queue entries; power of two, >= 2
- AW, 4, register address width (16 registers)
- DW, 32, data width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  execute presents a result
- in_ready  out  1  queue can accept; equals !full
- in_addr  in  AW  destination register
- in_data  in  DW  result value
- drain_en  in  1  register-bank write slot granted this cycle
- wb_en  out  1  registered write strobe to register bank
- wb_addr  out  AW  registered write address
- wb_data  out  DW  registered write data
- lk1_addr, lk2_addr  in  AW  operand-fetch read addresses (read ports 1, 2)
- fwd1_hit, fwd2_hit  out  1  a pending write to that address exists
- fwd1_data, fwd2_data  out  DW  newest pending value for that address (0 when no hit)
- count  out  clog2(DEPTH)+1  stored entries
- empty, full  out  1  count==0 / count==DEPTH

## Operation
- Push: in_valid && in_ready at a clock edge writes {in_addr, in_data} at the tail; tail pointer increments and wraps modulo DEPTH.
- Pop: drain_en && !empty at a clock edge moves the head entry into wb_addr/wb_data, sets wb_en=1 and advances the head pointer modulo DEPTH. Otherwise wb_en=0 at that edge and wb_addr/wb_data hold.
- Strictly in order; no coalescing of entries with the same address; address 0 is an ordinary register.
- Simultaneous push and pop with count>0: both take effect, count unchanged.
- Push into an empty queue with drain_en high: no pop that edge (empty is evaluated pre-edge); the entry pops at the next eligible edge.
- When full, in_ready=0 even if a pop occurs the same cycle; no push while full.
- in_valid without in_ready: no state change; execute holds its data.
- Forwarding (combinational, per lookup port): candidates are the stored queue entries plus the wb register when wb_en=1. Youngest match wins: tail-most queue entry first, then older queue entries, then the wb register. No match -> hit=0, data=0. The input port (in_addr/in_data) is never a forwarding source.
- Reset (any time, including mid-drain): head=tail=count=0, wb_en=0, wb_addr=0, wb_data=0; pending entries are discarded; storage array is not reset. After reset: in_ready=1, empty=1, full=0, both hit=0.

## Timing
- Accepted at edge N -> earliest wb_en=1 after edge N+1 -> register bank written at edge N+2.
- Queue full/empty flags, count and in_ready update on the same edge as push/pop.
- Forward outputs reflect the state after the most recent edge; lookup-to-output path is purely combinational.
- Throughput: one push and one pop per cycle in steady state.

## Test plan
- Reset then push (addr 3, 0xDEAD0003) with drain_en=1 -> wb_en=1 with addr 3, data 0xDEAD0003 exactly two edges after the push; count returns to 0.
- drain_en=0, push 4 entries (addrs 1,2,3,4) -> full=1, in_ready=0, count=4; a fifth in_valid is ignored; then drain_en=1 -> wb writes 1,2,3,4 in order on consecutive cycles.
- drain_en=0, push (5, 0x11) then (5, 0x22); lk1_addr=5 -> fwd1_hit=1, fwd1_data=0x22; lk2_addr=6 -> fwd2_hit=0, fwd2_data=0.
- Queue holding one entry (7, 0xAA) while wb register holds (7, 0x55) with wb_en=1 -> lookup 7 returns 0xAA; after drain, only wb holds (7, 0xAA) -> returns 0xAA; next cycle with wb_en=0 -> hit=0.
- Full queue with simultaneous in_valid and drain_en -> one pop, no push, count 3; next cycle push accepted, count 4; pointers wrap correctly over 10+ continuous push/pop cycles with data order preserved.
- Assert rst with 3 entries pending and wb_en=1 -> immediately wb_en=0, empty=1, count=0, hits=0; no further writes after release.
